// File: rtl/ltpi_pkg.sv
// rtl/ltpi_pkg.sv - shared types and constants for the LTPI data channel
//
// Purpose: payload record, command encoding, completion status codes,
// target FSM state type and the byte-lane masking helper.
// Ports: none (package).

package ltpi_pkg;

  typedef enum logic [7:0] {
    READ_REQ   = 8'h00,
    WRITE_REQ  = 8'h01,
    READ_COMP  = 8'h02,
    WRITE_COMP = 8'h03,
    CRC_ERROR  = 8'h04
  } dc_command_t;

  typedef struct packed {
    dc_command_t command;
    logic [7:0]  tag;
    logic [31:0] address;
    logic [3:0]  operation_status;
    logic [3:0]  byte_en;
    logic [31:0] data;
  } Data_channel_payload_t;

  localparam logic [3:0] DC_STATUS_OK      = 4'h0;
  localparam logic [3:0] DC_STATUS_SLV_ERR = 4'h1;
  localparam logic [3:0] DC_STATUS_TIMEOUT = 4'h2;

  // 1 ms of 60 MHz clock
  localparam int TIMER_1MS_60MHZ = 60000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RDATA,
    ST_WRESP,
    ST_SEND
  } dc_target_state_t;

  // Zero every byte lane whose enable bit is clear.
  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = be[b] ? d[b*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

endpackage

// File: rtl/logic_avalon_mm_if.sv
// rtl/logic_avalon_mm_if.sv - Avalon-MM local-bus interface
//
// Purpose: bundles the Avalon-MM request/response signals.
// Modports: master (drives address/read/write/chipselect/byteenable/writedata,
// receives readdata/readdatavalid/waitrequest/response/writeresponsevalid)
// and slave (the mirror image).

interface logic_avalon_mm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic                chipselect;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  logic [1:0]          response;
  logic                writeresponsevalid;

  modport master (
    output address, read, write, chipselect, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest, response, writeresponsevalid
  );

  modport slave (
    input  address, read, write, chipselect, byteenable, writedata,
    output readdata, readdatavalid, waitrequest, response, writeresponsevalid
  );
endinterface

// File: rtl/ltpi_dc_watchdog.sv
// rtl/ltpi_dc_watchdog.sv - local-bus transaction watchdog
//
// Purpose: 16-bit cycle counter that runs while a bus transaction is in
// flight and flags done once it reaches TIMEOUT_CYCLES-1.
// Ports: clk, rst (async active-high), run (count enable, low clears),
// done (timeout reached while running).

module ltpi_dc_watchdog #(
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic done
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;

  // Holds at the limit so done cannot wrap away if the owner lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 16'd0;
    end else if (!run) begin
      cnt <= 16'd0;
    end else if (!done) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign done = run && (cnt >= LIMIT);

endmodule

// File: rtl/ltpi_data_channel_target_mm.sv
// rtl/ltpi_data_channel_target_mm.sv - LTPI data channel responder to Avalon-MM
//
// Purpose: executes READ_REQ/WRITE_REQ payloads from the link as single
// Avalon-MM transactions and returns READ_COMP/WRITE_COMP payloads.
// One request outstanding; extra or unsupported requests are counted and dropped.
// Ports: clk, reset/data_channel_rst (async active-high), req_valid/req (request
// strobe and payload), resp_valid/resp_ack/resp (completion handshake),
// avalon_mm_m (Avalon-MM master), busy, dropped_cnt (saturating drop count).
// Optional build macro: LTPI_TARGET_WRITE_RESPONSE_EN (writes wait for
// writeresponsevalid; otherwise a write completes one cycle after acceptance).

module ltpi_data_channel_target_mm
  import ltpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMER_1MS_60MHZ,
  parameter int ADDR_W         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_channel_rst,
  input  logic                     req_valid,
  input  Data_channel_payload_t    req,
  output logic                     resp_valid,
  input  logic                     resp_ack,
  output Data_channel_payload_t    resp,
  logic_avalon_mm_if.master        avalon_mm_m,
  output logic                     busy,
  output logic [7:0]               dropped_cnt
);

  dc_target_state_t state, state_nx;

  logic [7:0]  tag_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  status_q;
  logic        is_write_q;

  logic is_req_cmd;
  logic accept;
  logic drop;
  logic wd_run;
  logic wd_done;
  logic rst_any;

  // Payload fields not consumed here are folded into a sink.
  logic unused_bits;
  assign unused_bits = ^{req, avalon_mm_m.writeresponsevalid};

  assign rst_any    = reset | data_channel_rst;
  assign is_req_cmd = (req.command == READ_REQ) || (req.command == WRITE_REQ);
  assign accept     = req_valid && (state == ST_IDLE) && is_req_cmd;
  assign drop       = req_valid && !accept;
  assign wd_run     = (state == ST_CMD) || (state == ST_RDATA) || (state == ST_WRESP);

  ltpi_dc_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk  (clk),
    .rst  (rst_any),
    .run  (wd_run),
    .done (wd_done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_CMD;
      // An accepted bus cycle wins over a watchdog expiry in the same cycle.
      ST_CMD: begin
        if (!avalon_mm_m.waitrequest) state_nx = is_write_q ? ST_WRESP : ST_RDATA;
        else if (wd_done)             state_nx = ST_SEND;
      end
      ST_RDATA: if (avalon_mm_m.readdatavalid || wd_done) state_nx = ST_SEND;
`ifdef LTPI_TARGET_WRITE_RESPONSE_EN
      ST_WRESP: if (avalon_mm_m.writeresponsevalid || wd_done) state_nx = ST_SEND;
`else
      ST_WRESP: state_nx = ST_SEND;
`endif
      ST_SEND:  if (resp_ack) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset or posedge data_channel_rst) begin
    if (reset || data_channel_rst) begin
      state       <= ST_IDLE;
      tag_q       <= 8'h00;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      status_q    <= DC_STATUS_OK;
      is_write_q  <= 1'b0;
      dropped_cnt <= 8'h00;
    end else begin
      state <= state_nx;
      if (drop && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'h01;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tag_q      <= req.tag;
            addr_q     <= req.address;
            be_q       <= req.byte_en;
            wdata_q    <= mask_bytes(req.data, req.byte_en);
            is_write_q <= (req.command == WRITE_REQ);
            // Cleared so write and timed-out completions carry zero data.
            rdata_q    <= 32'h0;
            status_q   <= DC_STATUS_OK;
          end
        end
        ST_CMD: begin
          if (avalon_mm_m.waitrequest && wd_done) status_q <= DC_STATUS_TIMEOUT;
        end
        ST_RDATA: begin
          if (avalon_mm_m.readdatavalid) begin
            rdata_q  <= mask_bytes(avalon_mm_m.readdata, be_q);
            status_q <= (avalon_mm_m.response == 2'b00) ? DC_STATUS_OK : DC_STATUS_SLV_ERR;
          end else if (wd_done) begin
            status_q <= DC_STATUS_TIMEOUT;
          end
        end
`ifdef LTPI_TARGET_WRITE_RESPONSE_EN
        ST_WRESP: begin
          if (avalon_mm_m.writeresponsevalid) begin
            status_q <= (avalon_mm_m.response == 2'b00) ? DC_STATUS_OK : DC_STATUS_SLV_ERR;
          end else if (wd_done) begin
            status_q <= DC_STATUS_TIMEOUT;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Strobes exist only in CMD, so leaving CMD (accept or timeout) drops them.
  assign avalon_mm_m.chipselect = (state == ST_CMD);
  assign avalon_mm_m.read       = (state == ST_CMD) && !is_write_q;
  assign avalon_mm_m.write      = (state == ST_CMD) && is_write_q;
  assign avalon_mm_m.address    = addr_q[ADDR_W-1:0];
  assign avalon_mm_m.byteenable = be_q;
  assign avalon_mm_m.writedata  = wdata_q;

  assign resp_valid = (state == ST_SEND);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    resp                  = '0;
    resp.command          = is_write_q ? WRITE_COMP : READ_COMP;
    resp.tag              = tag_q;
    resp.address          = addr_q;
    resp.byte_en          = be_q;
    resp.operation_status = status_q;
    resp.data             = rdata_q;
  end

endmodule
